// File: rtl/axis_ram_burst_writer_pkg.sv
// Shared types and constants for the AXI3 burst writer: FSM state encoding,
// fixed AXI attribute values and a ceiling-log2 helper for parameter math.
package axis_ram_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [3:0] AXI_CACHE_ALL  = 4'b1111;

  // Ceiling log2; returns 0 for values of 0 or 1.
  function automatic int clogb2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/axis_ram_burst_writer_fifo.sv
// Synchronous first-word-fall-through FIFO. A word pushed in cycle N is
// counted and presented on dout in cycle N+1. Push when full and pop when
// empty are ignored.
module axis_ram_fifo
  import axis_ram_pkg::*;
#(
  parameter int DEPTH = 512,
  parameter int WIDTH = 64,
  localparam int PW = clogb2(DEPTH)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [PW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign full    = count[PW];
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  // Storage array; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers and occupancy; a simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + {PW'(0), do_push} - {PW'(0), do_pop};
    end
  end

endmodule

// File: rtl/axis_ram_burst_writer.sv
// AXI3 burst writer draining an AXI4-Stream into a circular or one-shot
// DRAM buffer. Optional macro AXIS_RAM_BURST_WRITER_BRESP_EN makes sts_data
// report the pointer committed by write responses instead of beats sent.
// Handshake rule for every channel: a transfer happens on the rising clock
// edge where valid and ready are both high; a source holds valid and its
// payload stable until that edge.
module axis_ram_burst_writer
  import axis_ram_pkg::*;
#(
  parameter int ADDR_WIDTH       = 20,
  parameter int AXI_ID_WIDTH     = 6,
  parameter int AXI_ADDR_WIDTH   = 32,
  parameter int AXI_DATA_WIDTH   = 64,
  parameter int AXIS_TDATA_WIDTH = 64,
  parameter int BURST_LEN        = 16,
  parameter int FIFO_DEPTH       = 512
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [AXI_ADDR_WIDTH-1:0]   cfg_addr,
  input  logic [ADDR_WIDTH-1:0]       cfg_size,
  input  logic                        cfg_oneshot,
  output logic [ADDR_WIDTH-1:0]       sts_data,
  output logic [15:0]                 sts_wraps,
  output logic                        sts_done,
  output logic [1:0]                  dbg_state,
  output logic [AXI_ID_WIDTH-1:0]     m_axi_awid,
  output logic [AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [3:0]                  m_axi_awlen,
  output logic [2:0]                  m_axi_awsize,
  output logic [1:0]                  m_axi_awburst,
  output logic [3:0]                  m_axi_awcache,
  output logic                        m_axi_awvalid,
  input  logic                        m_axi_awready,
  output logic [AXI_ID_WIDTH-1:0]     m_axi_wid,
  output logic [AXI_DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                        m_axi_wlast,
  output logic                        m_axi_wvalid,
  input  logic                        m_axi_wready,
  input  logic                        m_axi_bvalid,
  output logic                        m_axi_bready,
  output logic                        s_axis_tready,
  input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                        s_axis_tvalid
);

  localparam int LOG_BL   = clogb2(BURST_LEN);
  localparam int SIZE_LOG = clogb2(AXI_DATA_WIDTH / 8);
  localparam int CW       = clogb2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0]         BL_CNT = CW'(BURST_LEN);
  localparam logic [ADDR_WIDTH-1:0] BL_PTR = ADDR_WIDTH'(BURST_LEN);

  state_t                    state, state_next;
  logic                      wvalid, wvalid_next;
  logic [ADDR_WIDTH-1:0]     ptr, ptr_next;
  logic [AXI_ID_WIDTH-1:0]   wid, wid_next;
  logic [15:0]               wraps, wraps_next;
  logic                      burst_start;
  logic [3:0]                aw_todo;
  logic [ADDR_WIDTH-1:0]     aw_ptr;
  logic [AXI_ID_WIDTH-1:0]   aw_id;
  logic [CW-1:0]             fifo_count;
  logic                      fifo_full;
  logic                      unused_fifo_empty;
  logic                      w_hs, aw_hs, last_beat, wrap_hit;

  axis_ram_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (AXI_DATA_WIDTH)
  ) u_fifo (
    .clk   (aclk),
    .rstn  (aresetn),
    .push  (s_axis_tvalid & s_axis_tready),
    .din   (AXI_DATA_WIDTH'(s_axis_tdata)),
    .pop   (w_hs),
    .dout  (m_axi_wdata),
    .full  (fifo_full),
    .empty (unused_fifo_empty),
    .count (fifo_count)
  );

  assign s_axis_tready = aresetn & ~fifo_full;
  assign w_hs          = wvalid & m_axi_wready;
  assign aw_hs         = m_axi_awvalid & m_axi_awready;
  assign last_beat     = &ptr[LOG_BL-1:0];
  assign wrap_hit      = (ptr + ADDR_WIDTH'(1)) == cfg_size;

  assign m_axi_wvalid  = wvalid;
  assign m_axi_wlast   = last_beat;
  assign m_axi_wid     = wid;
  assign m_axi_wstrb   = '1;
  assign m_axi_bready  = 1'b1;
  assign m_axi_awvalid = (aw_todo != '0);
  assign m_axi_awid    = aw_id;
  assign m_axi_awaddr  = cfg_addr + (AXI_ADDR_WIDTH'(aw_ptr) << SIZE_LOG);
  assign m_axi_awlen   = 4'(BURST_LEN - 1);
  assign m_axi_awsize  = 3'(SIZE_LOG);
  assign m_axi_awburst = AXI_BURST_INCR;
  assign m_axi_awcache = AXI_CACHE_ALL;
  assign sts_wraps     = wraps;
  assign sts_done      = (state == DONE);
  assign dbg_state     = state;

  // Burst sequencing: start bursts, count W beats, wrap and stop in one-shot.
  always_comb begin
    state_next  = state;
    wvalid_next = wvalid;
    ptr_next    = ptr;
    wid_next    = wid;
    wraps_next  = wraps;
    burst_start = 1'b0;
    case (state)
      IDLE: begin
        if (fifo_count >= BL_CNT) begin
          state_next  = BURST;
          wvalid_next = 1'b1;
          burst_start = 1'b1;
        end
      end
      BURST: begin
        if (w_hs) begin
          ptr_next = ptr + ADDR_WIDTH'(1);
          if (last_beat) begin
            wid_next = wid + AXI_ID_WIDTH'(1);
            if (wrap_hit) begin
              ptr_next = '0;
              if (wraps != 16'hFFFF) wraps_next = wraps + 16'd1;
            end
            if (wrap_hit && cfg_oneshot) begin
              state_next  = DONE;
              wvalid_next = 1'b0;
            end else if (fifo_count > BL_CNT) begin
              // Another full burst is already queued: keep wvalid high.
              burst_start = 1'b1;
            end else begin
              state_next  = IDLE;
              wvalid_next = 1'b0;
            end
          end
        end
      end
      DONE:    state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  // Sequencer state registers.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state  <= IDLE;
      wvalid <= 1'b0;
      ptr    <= '0;
      wid    <= '0;
      wraps  <= '0;
    end else begin
      state  <= state_next;
      wvalid <= wvalid_next;
      ptr    <= ptr_next;
      wid    <= wid_next;
      wraps  <= wraps_next;
    end
  end

  // Address issue tracks its own pointer and ID so AW may lag the W beats
  // without its address or ID drifting with the W-side counters.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      aw_todo <= '0;
      aw_ptr  <= '0;
      aw_id   <= '0;
    end else begin
      aw_todo <= aw_todo + {3'b0, burst_start} - {3'b0, aw_hs};
      if (aw_hs) begin
        aw_id  <= aw_id + AXI_ID_WIDTH'(1);
        aw_ptr <= ((aw_ptr + BL_PTR) == cfg_size) ? '0 : aw_ptr + BL_PTR;
      end
    end
  end

`ifdef AXIS_RAM_BURST_WRITER_BRESP_EN
  logic [ADDR_WIDTH-1:0] committed;

  // Committed pointer advances one burst per write response.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      committed <= '0;
    end else if (m_axi_bvalid) begin
      committed <= ((committed + BL_PTR) == cfg_size) ? '0 : committed + BL_PTR;
    end
  end

  assign sts_data = committed;
`else
  logic unused_bvalid;
  assign unused_bvalid = m_axi_bvalid;
  assign sts_data      = ptr;
`endif

endmodule

// File: doc/axis_ram_burst_writer.md
# axis_ram_burst_writer

Parametrised AXI3 burst writer that drains an AXI4-Stream into a circular or one-shot DRAM buffer through the PS HP port. It replaces the fixed 16-beat writer with configurable burst length, data width and FIFO depth, a software-defined buffer size with wrap-around, a one-shot mode and a wrap counter. It sits between a stream source (ADC or DSP chain) and an HP slave port, with `cfg`/`sts` wired to the register hub.

## Interface
- `ADDR_WIDTH`, 20: width of the beat pointer and `sts_data`.
- `AXI_ID_WIDTH`, 6: AWID/WID width.
- `AXI_ADDR_WIDTH`, 32: byte-address width.
- `AXI_DATA_WIDTH`, 64: W data width; must be 32, 64 or 128.
- `AXIS_TDATA_WIDTH`, 64: stream width; must be ≤ `AXI_DATA_WIDTH`, zero-extended.
- `BURST_LEN`, 16: beats per burst; must be 2, 4, 8 or 16.
- `FIFO_DEPTH`, 512: FIFO words; must be a power of two ≥ 2·`BURST_LEN`.

Ports:
- `aclk` in 1: the single clock.
- `aresetn` in 1: synchronous, active-low reset.
- `cfg_addr` in `AXI_ADDR_WIDTH`: buffer base byte address; must be 4 KB aligned.
- `cfg_size` in `ADDR_WIDTH`: buffer length in beats; must be a nonzero multiple of `BURST_LEN`.
- `cfg_oneshot` in 1: 0 selects continuous wrap, 1 stops at the end of the buffer.
- `sts_data` out `ADDR_WIDTH`: beat pointer (see Configuration).
- `sts_wraps` out 16: count of buffer wraps, saturating.
- `sts_done` out 1: one-shot buffer complete.
- `m_axi_aw*` (id, addr, len, size, burst, cache, valid / ready): AXI3 write-address channel.
- `m_axi_w*` (id, data, strb, last, valid / ready): AXI3 write-data channel.
- `m_axi_bvalid` in, `m_axi_bready` out: write-response channel.
- `s_axis_tready` out, `s_axis_tdata` in `AXIS_TDATA_WIDTH`, `s_axis_tvalid` in: stream input.

## Operation
- FIFO write happens on `s_axis_tvalid & s_axis_tready`.
- `s_axis_tready = ~fifo_full`. It is 0 while `aresetn` is low.
- State machine:
  - IDLE → BURST when FIFO count ≥ `BURST_LEN`. Both `awvalid` and `wvalid` are set.
  - In BURST, `awvalid` clears on the AW handshake.
  - Each W handshake pops the FIFO and increments `ptr`.
  - `wlast` is 1 when `ptr[log2(BURST_LEN)-1:0]` is all ones.
- On the last-beat handshake, in priority order:
  1. `ptr+1 == cfg_size`: `ptr` becomes 0 and `sts_wraps` increments. If `cfg_oneshot` is set, go to DONE.
  2. Otherwise, if FIFO count − 1 ≥ `BURST_LEN`, stay in BURST and set `awvalid` again in the same cycle.
  3. Otherwise, go to IDLE and clear `wvalid`.
- In continuous mode, case 1 falls through to the case 2/3 check.
- DONE: `sts_done` = 1 and no new bursts are issued. Only reset leaves DONE. Input keeps filling the FIFO until it is full.
- Constant AXI outputs:
  - `awaddr = cfg_addr + (ptr << log2(AXI_DATA_WIDTH/8))`, with `ptr` zero-extended.
  - `awlen = BURST_LEN-1`, `awsize = log2(AXI_DATA_WIDTH/8)`, `awburst = INCR`, `awcache = 4'b1111`.
  - `awid = wid` = a burst counter that increments on each last beat and wraps.
  - `wstrb` all ones, `bready = 1`.
- `cfg_*` must be held stable outside reset. Changing them mid-run is undefined.

## Timing
- Reset values:
  - Valid flags, `ptr`, `sts_data`, `sts_wraps`, `sts_done`, ID and FIFO are all 0.
  - State is IDLE.
- FIFO is first-word-fall-through. A word written in cycle N is counted and visible at its output in cycle N+1.
- `awvalid`/`wvalid` rise one cycle after the count reaches `BURST_LEN`.
- `wvalid` stays high across back-to-back bursts with no idle cycle. `wdata` is stable while `wready` is low.
- AW may complete before, during or after the W beats. A new AW is not raised until the previous burst's last beat has been accepted.
- Simultaneous FIFO push and pop update the count by 0.
- Reset asserted mid-burst abandons the burst. The AXI interconnect is reset together with this block.

## Configuration
- Macro: `AXIS_RAM_BURST_WRITER_BRESP_EN`.
- Defined: `sts_data` is the committed pointer. It advances by `BURST_LEN` on each `m_axi_bvalid` and wraps at `cfg_size`.
- Not defined: `sts_data = ptr`, i.e. beats accepted on W. No B-channel logic is built.

## Structure
- Package `axis_ram_pkg` holds:
  - the state enum (IDLE, BURST, DONE);
  - the AXI burst/cache constants;
  - the `clogb2` function.
- Sub-module `axis_ram_fifo`: a synchronous FWFT FIFO, `FIFO_DEPTH` × `AXI_DATA_WIDTH`, with full, empty and count outputs.

## Test plan
- BURST_LEN=4, cfg_addr=0x1000_0000, 8 words streamed: two bursts with awaddr 0x1000_0000 and 0x1000_0020, awlen=3, wlast on beats 4 and 8, awid 0 then 1.
- Continuous mode, cfg_size=8, 20 words: awaddr sequence …00, …20, …00, …20, …00; sts_wraps=2; sts_data=4.
- One-shot mode, cfg_size=8, 20 words: exactly 2 bursts; sts_done=1; no further awvalid; tready drops once the FIFO is full.
- Random `wready`/`awready` stalls (50%) over 1000 words: data order is preserved, `wdata` holds during stalls, and `wvalid` shows no gap when the FIFO holds ≥ 2 bursts.
- 3 words pushed then idle: no awvalid is issued; the 4th word causes awvalid one cycle later.
- With `AXIS_RAM_BURST_WRITER_BRESP_EN`, bvalid delayed 10 cycles: `sts_data` steps 0→4 only on bvalid.
